// File: rtl/cem_pkg.sv
// Shared encodings for count_event_monitor: event codes, FSM states and step classes.
package cem_pkg;

    localparam int TS_W = 16;

    localparam logic [2:0] EVT_NONE      = 3'd0;
    localparam logic [2:0] EVT_WRAP_UP   = 3'd1;
    localparam logic [2:0] EVT_WRAP_DN   = 3'd2;
    localparam logic [2:0] EVT_JUMP      = 3'd3;
    localparam logic [2:0] EVT_ALARM_SET = 3'd4;
    localparam logic [2:0] EVT_ALARM_CLR = 3'd5;

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_NORMAL = 2'd1;
    localparam logic [1:0] ST_ALARM  = 2'd2;

    typedef enum logic [1:0] {
        CLS_STEP    = 2'd0,
        CLS_WRAP_UP = 2'd1,
        CLS_WRAP_DN = 2'd2,
        CLS_JUMP    = 2'd3
    } step_cls_e;

    // A plain step produces no event.
    function automatic logic [2:0] cls_to_evt(input step_cls_e cls);
        logic [2:0] code;
        code = EVT_NONE;
        case (cls)
            CLS_WRAP_UP: code = EVT_WRAP_UP;
            CLS_WRAP_DN: code = EVT_WRAP_DN;
            CLS_JUMP:    code = EVT_JUMP;
            default:     code = EVT_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/count_step_classifier.sv
// Combinational classifier of one counter step: plain step, wrap up/down, or jump.
module count_step_classifier
    import cem_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev_q,
    input  logic [WIDTH-1:0] q_in,
    input  logic             mode_in,
    output step_cls_e        step_cls
);

    localparam logic [WIDTH-1:0] MAX_Q = {WIDTH{1'b1}};

    logic [WIDTH-1:0] up_q;
    logic [WIDTH-1:0] dn_q;

    assign up_q = prev_q + WIDTH'(1);
    assign dn_q = prev_q - WIDTH'(1);

    // Wrap cases are tested first so the modular +/-1 never hides them.
    always_comb begin
        step_cls = CLS_JUMP;
        if (mode_in && prev_q == MAX_Q && q_in == '0) begin
            step_cls = CLS_WRAP_UP;
        end else if (!mode_in && prev_q == '0 && q_in == MAX_Q) begin
            step_cls = CLS_WRAP_DN;
        end else if ((mode_in && q_in == up_q) || (!mode_in && q_in == dn_q)) begin
            step_cls = CLS_STEP;
        end
    end

endmodule

// File: rtl/count_event_monitor.sv
// Monitors an up/down counter: hysteresis alarm, wrap counter and a one-entry event slot.
// Optional macro COUNT_EVT_TIMESTAMP_EN stamps events with a free-running cycle count.
module count_event_monitor
    import cem_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8,
    parameter int HI_TH  = 12,
    parameter int LO_TH  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  q_in,
    input  logic              mode_in,
    input  logic              smp_valid,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [2:0]        evt_code,
    output logic [WIDTH-1:0]  evt_val,
    output logic [TS_W-1:0]   evt_ts,
    output logic              alarm,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              drop_sticky
);

    localparam logic [WIDTH-1:0] HI_Q = WIDTH'(HI_TH);
    localparam logic [WIDTH-1:0] LO_Q = WIDTH'(LO_TH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] prev_q;
    step_cls_e        step_cls;
    logic [2:0]       step_evt, alm_evt, new_evt;
    logic             load, drop, wrap_hit;

    count_step_classifier #(
        .WIDTH (WIDTH)
    ) u_cls (
        .prev_q   (prev_q),
        .q_in     (q_in),
        .mode_in  (mode_in),
        .step_cls (step_cls)
    );

    always_comb begin
        state_d  = state_q;
        step_evt = EVT_NONE;
        alm_evt  = EVT_NONE;
        wrap_hit = 1'b0;
        if (smp_valid) begin
            case (state_q)
                // A first sample already at or above HI_TH counts as an alarm rising edge.
                ST_INIT: begin
                    if (q_in >= HI_Q) begin
                        state_d = ST_ALARM;
                        alm_evt = EVT_ALARM_SET;
                    end else begin
                        state_d = ST_NORMAL;
                    end
                end
                ST_NORMAL: begin
                    if (q_in >= HI_Q) begin
                        state_d = ST_ALARM;
                        alm_evt = EVT_ALARM_SET;
                    end
                end
                ST_ALARM: begin
                    if (q_in <= LO_Q) begin
                        state_d = ST_NORMAL;
                        alm_evt = EVT_ALARM_CLR;
                    end
                end
                default: state_d = ST_INIT;
            endcase
            if (state_q != ST_INIT) begin
                step_evt = cls_to_evt(step_cls);
                wrap_hit = (step_cls == CLS_WRAP_UP) || (step_cls == CLS_WRAP_DN);
            end
        end
        new_evt = (step_evt != EVT_NONE) ? step_evt : alm_evt;
        load    = (new_evt != EVT_NONE) && (!evt_valid || evt_ready);
        drop    = ((step_evt != EVT_NONE) && (alm_evt != EVT_NONE)) ||
                  ((new_evt != EVT_NONE) && evt_valid && !evt_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            prev_q      <= '0;
            alarm       <= 1'b0;
            wrap_cnt    <= '0;
            drop_sticky <= 1'b0;
        end else begin
            if (smp_valid) begin
                state_q <= state_d;
                prev_q  <= q_in;
                alarm   <= (state_d == ST_ALARM);
            end
            if (wrap_hit && wrap_cnt != {WRAP_W{1'b1}}) begin
                wrap_cnt <= wrap_cnt + WRAP_W'(1);
            end
            if (drop) begin
                drop_sticky <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_code  <= EVT_NONE;
            evt_val   <= '0;
        end else if (load) begin
            evt_valid <= 1'b1;
            evt_code  <= new_evt;
            evt_val   <= q_in;
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

`ifdef COUNT_EVT_TIMESTAMP_EN
    // evt_ts holds the number of clock edges since reset release that preceded the load edge.
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q   <= '0;
            evt_ts <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (load) begin
                evt_ts <= ts_q;
            end
        end
    end
`else
    assign evt_ts = '0;
`endif

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed self-checking bench for count_event_monitor; honours COUNT_EVT_TIMESTAMP_EN.
module tb_count_event_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  q_in;
    logic        mode_in;
    logic        smp_valid;
    logic        evt_valid;
    logic        evt_ready;
    logic [2:0]  evt_code;
    logic [3:0]  evt_val;
    logic [15:0] evt_ts;
    logic        alarm;
    logic [7:0]  wrap_cnt;
    logic        drop_sticky;

    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] cyc;
    logic [15:0] t1, t2;

    count_event_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .q_in        (q_in),
        .mode_in     (mode_in),
        .smp_valid   (smp_valid),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_code    (evt_code),
        .evt_val     (evt_val),
        .evt_ts      (evt_ts),
        .alarm       (alarm),
        .wrap_cnt    (wrap_cnt),
        .drop_sticky (drop_sticky)
    );

    always #5 clk = ~clk;

    // Edges since reset release, mirroring the optional timestamp counter.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 16'd0;
        else     cyc <= cyc + 16'd1;
    end

    function automatic logic [15:0] ts_exp(input logic [15:0] c);
`ifdef COUNT_EVT_TIMESTAMP_EN
        return c - 16'd1;
`else
        return 16'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic smp(input logic [3:0] q, input logic m);
        q_in      = q;
        mode_in   = m;
        smp_valid = 1'b1;
        @(posedge clk);
        #1;
        smp_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; evt_ready = 1'b0; smp_valid = 1'b0; q_in = 4'd0; mode_in = 1'b0;
        idle(2);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_code", 32'(evt_code), 32'd0);
        chk("rst_val", 32'(evt_val), 32'd0);
        chk("rst_ts", 32'(evt_ts), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        chk("rst_wrap", 32'(wrap_cnt), 32'd0);
        chk("rst_drop", 32'(drop_sticky), 32'd0);
        rst = 1'b0;

        // Rising into alarm, consumer stalled.
        smp(4'd10, 1'b1);
        chk("init_alarm", 32'(alarm), 32'd0);
        chk("init_valid", 32'(evt_valid), 32'd0);
        smp(4'd11, 1'b1);
        chk("step_alarm", 32'(alarm), 32'd0);
        chk("step_valid", 32'(evt_valid), 32'd0);
        smp(4'd12, 1'b1);
        t1 = cyc;
        chk("set_alarm", 32'(alarm), 32'd1);
        chk("set_valid", 32'(evt_valid), 32'd1);
        chk("set_code", 32'(evt_code), 32'd4);
        chk("set_val", 32'(evt_val), 32'd12);
        chk("set_ts", 32'(evt_ts), 32'(ts_exp(t1)));
        chk("set_drop", 32'(drop_sticky), 32'd0);
        idle(2);
        chk("hold_valid", 32'(evt_valid), 32'd1);
        chk("hold_code", 32'(evt_code), 32'd4);

        // Jump into a full slot is lost; pending event untouched.
        smp(4'd7, 1'b1);
        chk("full_code", 32'(evt_code), 32'd4);
        chk("full_val", 32'(evt_val), 32'd12);
        chk("full_ts", 32'(evt_ts), 32'(ts_exp(t1)));
        chk("full_drop", 32'(drop_sticky), 32'd1);
        chk("full_alarm", 32'(alarm), 32'd1);
        evt_ready = 1'b1;
        idle(1);
        chk("drain_valid", 32'(evt_valid), 32'd0);

        // Count down through the hysteresis band.
        smp(4'd6, 1'b0);
        chk("dn6_alarm", 32'(alarm), 32'd1);
        chk("dn6_valid", 32'(evt_valid), 32'd0);
        smp(4'd5, 1'b0);
        smp(4'd4, 1'b0);
        chk("dn4_alarm", 32'(alarm), 32'd1);
        smp(4'd3, 1'b0);
        chk("clr_alarm", 32'(alarm), 32'd0);
        chk("clr_valid", 32'(evt_valid), 32'd1);
        chk("clr_code", 32'(evt_code), 32'd5);
        chk("clr_val", 32'(evt_val), 32'd3);
        chk("clr_ts", 32'(evt_ts), 32'(ts_exp(cyc)));

        // Back-to-back: new event loads in the transfer cycle.
        smp(4'd7, 1'b1);
        chk("b2b_valid", 32'(evt_valid), 32'd1);
        chk("b2b_code", 32'(evt_code), 32'd3);
        chk("b2b_val", 32'(evt_val), 32'd7);
        smp(4'd0, 1'b1);
        chk("rst0_code", 32'(evt_code), 32'd3);
        chk("rst0_val", 32'(evt_val), 32'd0);
        chk("rst0_alarm", 32'(alarm), 32'd0);

        // Wraps win over the simultaneous alarm edges.
        smp(4'd15, 1'b0);
        chk("wdn_code", 32'(evt_code), 32'd2);
        chk("wdn_val", 32'(evt_val), 32'd15);
        chk("wdn_wrap", 32'(wrap_cnt), 32'd1);
        chk("wdn_alarm", 32'(alarm), 32'd1);
        smp(4'd0, 1'b1);
        chk("wup_code", 32'(evt_code), 32'd1);
        chk("wup_val", 32'(evt_val), 32'd0);
        chk("wup_wrap", 32'(wrap_cnt), 32'd2);
        chk("wup_alarm", 32'(alarm), 32'd0);
        smp(4'd1, 1'b0);
        chk("dir_code", 32'(evt_code), 32'd3);
        chk("dir_val", 32'(evt_val), 32'd1);
        smp(4'd2, 1'b1);
        chk("quiet_valid", 32'(evt_valid), 32'd0);

        // Invalid samples must not touch prev_q.
        q_in = 4'd9; mode_in = 1'b1;
        idle(1);
        chk("nv_valid", 32'(evt_valid), 32'd0);
        chk("nv_wrap", 32'(wrap_cnt), 32'd2);
        smp(4'd3, 1'b1);
        chk("nv_prev", 32'(evt_valid), 32'd0);

        // Stalled slot: later jump and wrap lost, wrap still counted.
        evt_ready = 1'b0;
        smp(4'd8, 1'b1);
        t2 = cyc;
        smp(4'd15, 1'b1);
        smp(4'd0, 1'b1);
        chk("stall_valid", 32'(evt_valid), 32'd1);
        chk("stall_code", 32'(evt_code), 32'd3);
        chk("stall_val", 32'(evt_val), 32'd8);
        chk("stall_ts", 32'(evt_ts), 32'(ts_exp(t2)));
        chk("stall_wrap", 32'(wrap_cnt), 32'd3);
        chk("stall_alarm", 32'(alarm), 32'd0);

        // Asynchronous reset mid-operation.
        rst = 1'b1;
        #1;
        chk("mid_valid", 32'(evt_valid), 32'd0);
        chk("mid_code", 32'(evt_code), 32'd0);
        chk("mid_wrap", 32'(wrap_cnt), 32'd0);
        chk("mid_drop", 32'(drop_sticky), 32'd0);
        #1;
        rst = 1'b0;
        evt_ready = 1'b1;
        smp(4'd13, 1'b1);
        chk("reinit_alarm", 32'(alarm), 32'd1);
        chk("reinit_wrap", 32'(wrap_cnt), 32'd0);
        smp(4'd14, 1'b1);
        smp(4'd15, 1'b1);
        smp(4'd0, 1'b1);
        chk("rewrap_code", 32'(evt_code), 32'd1);
        chk("rewrap_wrap", 32'(wrap_cnt), 32'd1);

        // Saturation: 260 more wraps from prev_q=0.
        for (int i = 0; i < 130; i++) begin
            smp(4'd15, 1'b0);
            smp(4'd0, 1'b1);
        end
        chk("sat_wrap", 32'(wrap_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
